// File: rtl/softmax_pkg.sv
// softmax_pkg: definitions shared by the softmax datapath blocks (shifter, log2 encoder and
// future log/exp units).
//   softmax_state_e    : IDLE / SEARCH / DONE sequencing used by the iterative blocks
//   softmax_nstep()    : number of binary-search halving steps for a given BITWIDTH
//   softmax_int_width(): width of the integer (k) field of a fixed-point log result
//   softmax_lz_width() : width of a leading-zero count that can hold BITWIDTH itself
//   softmax_int_lsb()  : bit position of the integer field (directly above the fraction)
package softmax_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } softmax_state_e;

  localparam int unsigned SoftmaxFracLsb = 0;

  function automatic int unsigned softmax_nstep(input int unsigned bitwidth);
    return $clog2(bitwidth);
  endfunction

  function automatic int unsigned softmax_int_width(input int unsigned bitwidth);
    return $clog2(bitwidth);
  endfunction

  function automatic int unsigned softmax_lz_width(input int unsigned bitwidth);
    return $clog2(bitwidth) + 1;
  endfunction

  function automatic int unsigned softmax_int_lsb(input int unsigned fracbits);
    return fracbits;
  endfunction

endpackage

// File: rtl/lod_norm_step.sv
// lod_norm_step: one combinational halving step of the leading-one normaliser.
//   norm_i / lz_i : current normalised operand and accumulated leading-zero count
//   step_i        : step index s; the window examined is w = 2^s bits wide
//   norm_o / lz_o : operand shifted left by w and count bumped by w when the top w bits
//                   are all zero, otherwise passed through unchanged
module lod_norm_step #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned LzW      = 6,
  parameter int unsigned StepW    = 3
) (
  input  logic [BITWIDTH-1:0] norm_i,
  input  logic [LzW-1:0]      lz_i,
  input  logic [StepW-1:0]    step_i,
  output logic [BITWIDTH-1:0] norm_o,
  output logic [LzW-1:0]      lz_o
);

  int unsigned w;

  always_comb begin
    w      = 32'd1 << step_i;
    norm_o = norm_i;
    lz_o   = lz_i;
    // Top w bits empty: the leading one is further down, so skip the whole window.
    if ((norm_i >> (BITWIDTH - w)) == '0) begin
      norm_o = norm_i << w;
      lz_o   = lz_i + LzW'(w);
    end
  end

endmodule

// File: rtl/log2_encoder.sv
// log2_encoder: fixed-point base-2 logarithm by Mitchell's approximation.
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   Start        : request, sampled when not Busy (IDLE or DONE)
//   Datain       : operand x, captured on the accept edge
//   Busy         : high while the binary-search normaliser is running
//   DataOut_vld  : one-cycle registered result strobe
//   Zero         : x was 0 (valid with DataOut_vld)
//   DataOut      : {0, k = floor(log2 x), FRACBITS bits below the leading one}
module log2_encoder
  import softmax_pkg::*;
#(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned FRACBITS = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [BITWIDTH-1:0] Datain,
  output logic                Busy,
  output logic                DataOut_vld,
  output logic                Zero,
  output logic [BITWIDTH-1:0] DataOut
);

  localparam int unsigned NStep = softmax_nstep(BITWIDTH);
  localparam int unsigned IntW  = softmax_int_width(BITWIDTH);
  localparam int unsigned LzW   = softmax_lz_width(BITWIDTH);
  localparam int unsigned IntLsb = softmax_int_lsb(FRACBITS);
  localparam int unsigned StepW = (NStep > 1) ? $clog2(NStep) : 1;

  softmax_state_e state_q, state_d;
  logic [BITWIDTH-1:0] norm_q, norm_d, step_norm;
  logic [LzW-1:0]      lz_q, lz_d, step_lz;
  logic [StepW-1:0]    step_q, step_d;
  logic                accept;

  logic                vld_q, vld_d;
  logic                zero_q, zero_d;
  logic [BITWIDTH-1:0] dout_q, dout_d;

  lod_norm_step #(
    .BITWIDTH(BITWIDTH),
    .LzW     (LzW),
    .StepW   (StepW)
  ) u_step (
    .norm_i(norm_q),
    .lz_i  (lz_q),
    .step_i(step_q),
    .norm_o(step_norm),
    .lz_o  (step_lz)
  );

  always_comb begin
    state_d = state_q;
    norm_d  = norm_q;
    lz_d    = lz_q;
    step_d  = step_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: accept = Start;
      StSearch: begin
        norm_d = step_norm;
        lz_d   = step_lz;
        if (step_q == '0) begin
          state_d = StDone;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      StDone: begin
        accept  = Start;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // DONE can take a new operand directly, giving back-to-back results.
    if (accept) begin
      state_d = StSearch;
      norm_d  = Datain;
      lz_d    = '0;
      step_d  = StepW'(NStep - 1);
    end
  end

  // Result is formed from the settled norm/lz while in DONE and registered out.
  always_comb begin
    vld_d  = (state_q == StDone);
    zero_d = 1'b0;
    dout_d = '0;
    if (state_q == StDone) begin
      if (norm_q == '0) begin
        zero_d = 1'b1;
      end else begin
        dout_d[IntLsb +: IntW]        = IntW'(LzW'(BITWIDTH - 1) - lz_q);
        dout_d[FRACBITS-1:0]          = norm_q[BITWIDTH-2 -: FRACBITS];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      norm_q  <= '0;
      lz_q    <= '0;
      step_q  <= '0;
      vld_q   <= 1'b0;
      zero_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      norm_q  <= norm_d;
      lz_q    <= lz_d;
      step_q  <= step_d;
      vld_q   <= vld_d;
      zero_q  <= zero_d;
      dout_q  <= dout_d;
    end
  end

  assign Busy        = (state_q == StSearch);
  assign DataOut_vld = vld_q;
  assign Zero        = zero_q;
  assign DataOut     = dout_q;

endmodule

// File: tb/tb_log2_encoder.sv
module tb_log2_encoder;

  localparam int BW    = 32;
  localparam int FB    = 8;
  localparam int NSTEP = 5;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [BW-1:0] Datain = '0;
  logic          Busy, DataOut_vld, Zero;
  logic [BW-1:0] DataOut;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  // Reference model state (updated on rising edges from sampled inputs).
  bit            inflight = 0;
  int            age = 0;
  logic [BW-1:0] op = '0;
  bit            exp_vld = 0, exp_zero = 0, exp_busy = 0;
  logic [BW-1:0] exp_out = '0;

  log2_encoder #(.BITWIDTH(BW), .FRACBITS(FB)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Datain     (Datain),
    .Busy       (Busy),
    .DataOut_vld(DataOut_vld),
    .Zero       (Zero),
    .DataOut    (DataOut)
  );

  always #5 Clock = ~Clock;

  // k = highest set bit; fraction = floor((x - 2^k) * 2^FB / 2^k).
  function automatic logic [BW-1:0] ref_data(input logic [BW-1:0] x);
    int k;
    longint unsigned frac;
    if (x == 0) return '0;
    k = 0;
    for (int i = 0; i < BW; i++) if (x[i]) k = i;
    frac = ((longint'(x) - (64'd1 << k)) << FB) >> k;
    return BW'((longint'(k) << FB) | frac);
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : model
    forever begin
      @(posedge Clock);
      if (Reset) begin
        inflight = 0; age = 0;
        exp_vld = 0; exp_zero = 0; exp_out = '0;
      end else begin
        exp_vld = 0; exp_zero = 0; exp_out = '0;
        if (inflight) begin
          age++;
          if (age == NSTEP + 1) begin
            exp_vld  = 1;
            exp_out  = ref_data(op);
            exp_zero = (op == 0);
            inflight = 0;
          end
        end
        if (!inflight && Start) begin
          inflight = 1; age = 0; op = Datain;
        end
      end
      exp_busy = inflight && (age < NSTEP);
    end
  end

  initial begin : compare
    forever begin
      @(negedge Clock);
      if (checking) begin
        check("vld", {31'd0, DataOut_vld}, {31'd0, exp_vld});
        check("zero", {31'd0, Zero}, {31'd0, exp_zero});
        check("busy", {31'd0, Busy}, {31'd0, exp_busy});
        check("dout", DataOut, exp_out);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic run_one(input logic [BW-1:0] x, input logic [BW-1:0] exp_d, input bit exp_z,
                         input string name, input bit mid_pulse);
    int n;
    Datain = x;
    Start  = 1'b1;
    @(negedge Clock);
    Start  = 1'b0;
    Datain = $urandom;
    n = 1;
    while (!DataOut_vld && n < 20) begin
      if (mid_pulse && n == 3) begin
        Start  = 1'b1;
        Datain = 32'h1234_5678;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clock);
      n++;
    end
    Start = 1'b0;
    check({name, "_latency"}, 32'(n), 32'd7);
    check({name, "_data"}, DataOut, exp_d);
    check({name, "_zero"}, {31'd0, Zero}, {31'd0, exp_z});
    @(negedge Clock);
    check({name, "_pulse_width"}, {31'd0, DataOut_vld}, 32'd0);
  endtask

  initial begin : stim
    int last;
    int cyc;
    logic [BW-1:0] x;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    checking = 1;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_vld", {31'd0, DataOut_vld}, 32'd0);
    check("reset_dout", DataOut, 32'd0);

    // Hand-computed expectations.
    run_one(32'h0000_0001, 32'h0000_0000, 1'b0, "one", 1'b0);
    run_one(32'h0000_0300, 32'h0000_0980, 1'b0, "x300", 1'b0);
    run_one(32'hFFFF_FFFF, 32'h0000_1FFF, 1'b0, "allones", 1'b0);
    run_one(32'h8000_0000, 32'h0000_1F00, 1'b0, "msb", 1'b0);
    run_one(32'h0000_0000, 32'h0000_0000, 1'b1, "zero", 1'b0);
    for (int n = 0; n < BW; n++) begin
      x = 32'd1 << n;
      run_one(x, 32'(n) << FB, 1'b0, "pow2", 1'b0);
    end

    // Start during SEARCH must be ignored.
    run_one(32'h0000_0300, 32'h0000_0980, 1'b0, "midstart", 1'b1);

    // Start held high: results every NSTEP+1 cycles.
    last = -1;
    Start = 1'b1;
    for (cyc = 0; cyc < 40; cyc++) begin
      Datain = $urandom >> $urandom_range(0, 31);
      @(negedge Clock);
      if (DataOut_vld) begin
        if (last >= 0) check("b2b_gap", 32'(cyc - last), 32'(NSTEP + 1));
        last = cyc;
      end
    end
    Start = 1'b0;
    repeat (8) @(negedge Clock);

    // Reset mid-search aborts; nothing emerges, next request is normal.
    Datain = 32'h0000_0300;
    Start  = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("abort_novld", {31'd0, DataOut_vld}, 32'd0);
      check("abort_dout", DataOut, 32'd0);
      @(negedge Clock);
    end
    run_one(32'h0000_0300, 32'h0000_0980, 1'b0, "after_reset", 1'b0);

    // Random operands with random idle gaps.
    repeat (150) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) x = '0;
      run_one(x, ref_data(x), (x == 0), "rand", $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 3)) @(negedge Clock);
    end

    repeat (4) @(negedge Clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/log2_encoder.md
# log2_encoder

Inverse of the softmax power-of-two shifter: takes an unsigned BITWIDTH-bit value and returns its base-2 logarithm as fixed point, using Mitchell's approximation. The integer part is floor(log2 x); the fraction is the FRACBITS bits immediately below the leading one. The block sits on the normalisation/log path of the softmax datapath and uses the same Start / DataOut_vld / DataOut convention as the shifter. It is an iterative binary-search normaliser, one halving step per cycle.

## Interface
- BITWIDTH, 32: input and output width; power of two, ≥ 4.
- FRACBITS, 8: fraction bits in DataOut. Constraints: FRACBITS ≤ BITWIDTH-1 and FRACBITS + clog2(BITWIDTH) ≤ BITWIDTH.
- Clock  in  1  clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- Datain  in  BITWIDTH  operand x; captured in the accept cycle.
- Busy  out  1  high while a search is in progress.
- DataOut_vld  out  1  one-cycle result strobe.
- Zero  out  1  x was 0; valid with DataOut_vld.
- DataOut  out  BITWIDTH  bits [FRACBITS +: clog2(BITWIDTH)] hold k = floor(log2 x); bits [FRACBITS-1:0] hold the fraction; all upper bits are 0.

## Operation
- States:
  - IDLE: waiting for a request.
  - SEARCH: runs for NSTEP = clog2(BITWIDTH) cycles.
  - DONE: the result cycle.
- IDLE, Start=1: capture Datain into norm, clear lz, set step = NSTEP-1, go to SEARCH.
- SEARCH step s, with w = 2^s:
  - If norm[BITWIDTH-1 -: w] == 0: norm <= norm << w and lz <= lz + w.
  - Decrement step. After step 0, go to DONE.
- DONE: DataOut_vld=1.
  - If norm==0: Zero=1, DataOut=0.
  - Otherwise: k = BITWIDTH-1-lz, fraction = norm[BITWIDTH-2 -: FRACBITS].
- DONE, Start=1: accept the new operand exactly as from IDLE and go to SEARCH. DONE, Start=0: go to IDLE.
- Start while in SEARCH is ignored; it is neither queued nor able to corrupt the in-flight operand.
- Outside the DONE cycle, DataOut=0, Zero=0 and DataOut_vld=0.
- Arithmetic: lz is clog2(BITWIDTH)+1 bits wide, so the value BITWIDTH cannot overflow. The fraction is truncated; no rounding.

## Timing
- Reset values: state=IDLE, Busy=0, DataOut_vld=0, Zero=0, DataOut=0; norm, lz and step are cleared.
- Reset asserted mid-SEARCH or in DONE aborts the operation. No DataOut_vld follows.
- Latency: Start accepted at edge E → DataOut_vld high in the cycle after edge E+NSTEP+1. For BITWIDTH=32 that is after edge E+6.
- Busy is high after edge E through the end of the last SEARCH cycle. Busy is low in DONE.
- Throughput: one result per NSTEP+1 cycles when Start is held high.
- Outputs are registered; there is no combinational path from Datain or Start to any output.

## Structure
- Shared package softmax_pkg holds:
  - the state enum (IDLE/SEARCH/DONE);
  - the NSTEP and integer-field-width localparams, derived as functions of BITWIDTH;
  - the DataOut field-position constants. The shifter and future log/exp blocks reuse these.
- One natural sub-module, lod_norm_step: combinational. Given norm, lz and w, it returns the next norm and lz. It is instantiated once and driven by step.

## Test plan
- Values below assume BITWIDTH=32, FRACBITS=8.
- Datain=0x00000001 → after 6 cycles, DataOut=0x00000000, Zero=0, DataOut_vld pulse of exactly 1 cycle.
- Datain=0x00000300 → DataOut=0x00000980 (k=9, frac=0x80). Datain=0xFFFFFFFF → DataOut=0x00001FFF. Datain=0x80000000 → DataOut=0x00001F00.
- Datain=0 → DataOut=0, Zero=1, DataOut_vld=1.
- Round trip: for n=0..31, Datain=1<<n → DataOut=n<<8, Zero=0.
- Start held high with a new operand each accept → results are back-to-back every 6 cycles. A Start pulse mid-SEARCH carrying 0x12345678 is ignored; the original result is unchanged.
- Reset pulsed 3 cycles into SEARCH → no DataOut_vld, all outputs 0, and the next Start behaves normally.
